// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter: pops one byte per frame, pulses tx_start,
// and waits for tx_done before offering the next byte.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no frame in flight; pops the head when FIFO non-empty and TX idle
// SEND      | tx_start high for this single cycle
// WAIT_DONE | frame in flight, tx_data held until tx_done
module uart_tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_busy,
  input  logic                  tx_done
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   wr_ptr_nxt;
  logic [ADDR_WIDTH:0]   rd_ptr_nxt;
  logic [ADDR_WIDTH:0]   level_nxt;
  logic                  pop;
  logic                  push;

  // A pop frees a slot on the same edge, so a full FIFO still accepts a write then.
  assign pop  = (state == IDLE) && !empty && !tx_busy && !flush;
  assign push = wr_en && !flush && (!full || pop);

  always_comb begin
    wr_ptr_nxt = wr_ptr + (ADDR_WIDTH+1)'(push);
    rd_ptr_nxt = flush ? wr_ptr : rd_ptr + (ADDR_WIDTH+1)'(pop);
    level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      level    <= level_nxt;
      full     <= (level_nxt == (ADDR_WIDTH+1)'(FIFO_DEPTH));
      empty    <= (level_nxt == '0);
      overflow <= wr_en && !flush && full && !pop;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data  <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            tx_start <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          tx_start <= 1'b0;
          state    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) state <= IDLE;
        end
        default: begin
          tx_start <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: queue-based reference model plus a simple UART TX
// responder, checked every cycle, with directed scenarios and a random phase.
module tb_uart_tx_feeder;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          flush = 1'b0;
  logic          full, empty, overflow, tx_start;
  logic [AW:0]   level;
  logic [DW-1:0] tx_data;
  logic          tx_busy = 1'b0;
  logic          tx_done = 1'b0;

  uart_tx_feeder #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: byte queue plus "frame in flight" bookkeeping
  logic [DW-1:0] q[$];
  bit            m_in_flight;
  bit            m_start;
  logic [DW-1:0] m_data;
  bit            m_ovf;

  // transmitter responder and observations
  int            tx_cnt;
  bit            tx_busy_int;
  bit            hold_busy;
  bit            stray_en;
  logic [DW-1:0] sent[$];
  int            ovf_cnt;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit we, input logic [DW-1:0] wd, input bit fl,
                            input bit busy, input bit done);
    bit pop, acc;
    pop = !m_in_flight && (q.size() > 0) && !busy && !fl;
    acc = we && !fl && ((q.size() < DEPTH) || pop);
    m_ovf = we && !fl && (q.size() == DEPTH) && !pop;
    if (m_in_flight && !m_start && done) m_in_flight = 0;
    if (pop) begin
      m_data = q.pop_front();
      m_in_flight = 1;
    end
    m_start = pop;
    if (fl) q.delete();
    if (acc) q.push_back(wd);
  endtask

  task automatic compare();
    check("tx_start", int'(tx_start), int'(m_start));
    check("tx_data", int'(tx_data), int'(m_data));
    check("level", int'(level), q.size());
    check("empty", int'(empty), int'(q.size() == 0));
    check("full", int'(full), int'(q.size() == DEPTH));
    check("overflow", int'(overflow), int'(m_ovf));
    if (overflow === 1'b1) ovf_cnt++;
  endtask

  task automatic tx_model();
    tx_done = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_done = 1'b1;
        tx_busy_int = 0;
      end
    end else if (tx_start === 1'b1) begin
      tx_busy_int = 1;
      tx_cnt = $urandom_range(2, 6);
      sent.push_back(tx_data);
    end else if (stray_en && ($urandom_range(0, 7) == 0)) begin
      tx_done = 1'b1;
    end
    tx_busy = tx_busy_int | hold_busy;
  endtask

  task automatic step(input bit we, input logic [DW-1:0] wd, input bit fl);
    bit b, d;
    wr_en = we; wr_data = wd; flush = fl;
    b = tx_busy; d = tx_done;
    @(posedge clk);
    model_edge(we, wd, fl, b, d);
    #1;
    compare();
    tx_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0);
  endtask

  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    check("rst_tx_start", int'(tx_start), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_level", int'(level), 0);
    check("rst_overflow", int'(overflow), 0);
    q.delete();
    m_in_flight = 0; m_start = 0; m_data = '0; m_ovf = 0;
    tx_cnt = 0; tx_busy_int = 0; tx_done = 1'b0; tx_busy = hold_busy;
    wr_en = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    hold_busy = 0; stray_en = 0; tx_cnt = 0; tx_busy_int = 0; ovf_cnt = 0;
    do_reset();

    // single byte
    step(1, 8'hA5, 0);
    check("single_empty_after_write", int'(empty), 0);
    check("single_level_after_write", int'(level), 1);
    step(0, '0, 0);
    check("single_start", int'(tx_start), 1);
    check("single_data", int'(tx_data), 8'hA5);
    check("single_empty_after_pop", int'(empty), 1);
    step(0, '0, 0);
    check("single_start_one_cycle", int'(tx_start), 0);
    idle(10);
    check("single_sent_count", sent.size(), 1);
    if (sent.size() == 1) check("single_sent_byte", int'(sent[0]), 8'hA5);

    // burst 01..05
    sent.delete();
    for (int i = 1; i <= 5; i++) step(1, DW'(i), 0);
    idle(60);
    check("burst_count", sent.size(), 5);
    for (int i = 0; i < sent.size() && i < 5; i++) check("burst_order", int'(sent[i]), i + 1);
    check("burst_level_end", int'(level), 0);

    // full and overflow
    sent.delete(); ovf_cnt = 0;
    hold_busy = 1; tx_busy = 1'b1;
    for (int i = 0; i < 17; i++) step(1, DW'(8'h10 + i), 0);
    step(0, '0, 0);
    check("full_level", int'(level), 16);
    check("full_flag", int'(full), 1);
    check("overflow_pulses", ovf_cnt, 1);
    hold_busy = 0; tx_busy = tx_busy_int;
    idle(200);
    check("full_sent_count", sent.size(), 16);
    for (int i = 0; i < sent.size() && i < 16; i++) check("full_sent_byte", int'(sent[i]), 8'h10 + i);

    // full plus simultaneous pop
    sent.delete(); ovf_cnt = 0;
    hold_busy = 1; tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) step(1, DW'(8'h40 + i), 0);
    hold_busy = 0; tx_busy = tx_busy_int;
    step(1, 8'hEE, 0);
    check("fullpop_overflow", int'(overflow), 0);
    check("fullpop_level", int'(level), 16);
    check("fullpop_start", int'(tx_start), 1);
    idle(250);
    check("fullpop_sent_count", sent.size(), 17);
    if (sent.size() == 17) check("fullpop_last_byte", int'(sent[16]), 8'hEE);
    check("fullpop_ovf_count", ovf_cnt, 0);

    // flush during first frame
    sent.delete();
    for (int i = 0; i < 4; i++) step(1, DW'(8'h60 + i), 0);
    step(0, '0, 1);
    idle(30);
    check("flush_sent_count", sent.size(), 1);
    if (sent.size() == 1) check("flush_first_byte", int'(sent[0]), 8'h60);
    check("flush_level", int'(level), 0);
    check("flush_empty", int'(empty), 1);

    // reset mid-frame
    sent.delete();
    step(1, 8'h77, 0);
    idle(3);
    do_reset();
    step(1, 8'h3C, 0);
    idle(15);
    check("rst_resume_count", sent.size(), 2);
    if (sent.size() == 2) check("rst_resume_byte", int'(sent[1]), 8'h3C);

    // random traffic
    stray_en = 1;
    for (int c = 0; c < 2000; c++) begin
      if ((c % 64) == 0) hold_busy = ($urandom_range(0, 2) == 0);
      if (c == 1000) do_reset();
      step($urandom_range(0, 1) == 1, DW'($urandom_range(0, 255)), $urandom_range(0, 49) == 0);
    end
    hold_busy = 0; stray_en = 0;
    idle(300);
    check("final_level", int'(level), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
